// File: rtl/lfsr16_checker.sv
// Locks onto a 16-bit Fibonacci LFSR stream (x^16+x^14+x^13+x^11+1) and flags mismatching words.
// Optional statistics counters are built when LFSR16_CHECKER_STATS_EN is defined.
module lfsr16_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [15:0] data_i,
    input  logic        clr_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [15:0] err_cnt_o,
    output logic [31:0] smp_cnt_o
);

    localparam logic [3:0] LockC   = 4'(LOCK_CNT);
    localparam logic [3:0] UnlockC = 4'(UNLOCK_CNT);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pred_q, pred_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        err_q, err_d;

    function automatic logic [15:0] step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        if (valid_i) begin
            unique case (state_q)
                HUNT: begin
                    pred_d = step(data_i);
                    if (pred_q != 16'h0 && data_i == pred_q) begin
                        if (match_q + 4'd1 == LockC) begin
                            state_d = LOCKED;
                            match_d = 4'd0;
                        end else begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    pred_d = step(pred_q);
                    if (data_i == pred_q) begin
                        miss_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q + 4'd1 == UnlockC) begin
                            state_d = HUNT;
                            miss_d  = 4'd0;
                            match_d = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HUNT;
            pred_q  <= 16'h0;
            match_q <= 4'd0;
            miss_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign locked_o = (state_q == LOCKED);
    assign err_o    = err_q;

`ifdef LFSR16_CHECKER_STATS_EN
    logic [15:0] err_cnt_q;
    logic [31:0] smp_cnt_q;

    // Counters move on the same edge that accepts the sample, so a clear wins
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            err_cnt_q <= 16'h0;
            smp_cnt_q <= 32'h0;
        end else begin
            if (err_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            if (valid_i && state_q == LOCKED) begin
                smp_cnt_q <= smp_cnt_q + 32'd1;
            end
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign smp_cnt_o = smp_cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign err_cnt_o  = 16'h0;
    assign smp_cnt_o  = 32'h0;
`endif

endmodule
